// File: rtl/k12a_mem_arbiter_if.sv
// Signal bundle around the K12a memory arbiter: CPU bus, host port and memory device.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface k12a_mem_arbiter_if;
    logic        cpu_mem_enable;
    logic        cpu_mem_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_run;
    logic        host_req;
    logic        host_write;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        mem_enable;
    logic        mem_mode;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_mem_enable, cpu_mem_mode, cpu_addr, cpu_wdata,
        input  host_req, host_write, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_run, host_ack, host_rdata,
        output mem_enable, mem_mode, mem_addr, mem_wdata
    );

    modport master (
        output cpu_mem_enable, cpu_mem_mode, cpu_addr, cpu_wdata,
        output host_req, host_write, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_run, host_ack, host_rdata,
        input  mem_enable, mem_mode, mem_addr, mem_wdata
    );
endinterface

// File: rtl/k12a_mem_arbiter.sv
// Shares the K12a main-memory port between the CPU (priority) and a host port.
// The host takes CPU-idle cycles, or stalls the CPU for one cycle after MAX_WAIT busy cycles.
module k12a_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    k12a_mem_arbiter_if.slave  bus
);

    localparam logic       MODE_READ  = 1'b0;
    localparam logic       MODE_WRITE = 1'b1;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  wait_cnt_r;
    logic [3:0]  wait_cnt_next_s;
    logic [3:0]  wait_cnt_inc_s;
    logic [7:0]  host_rdata_r;
    logic        host_grant_s;
    logic        mem_enable_s;
    logic        mem_mode_s;
    logic [15:0] mem_addr_s;
    logic [7:0]  mem_wdata_s;

    // A STALL cycle belongs to the host regardless of what the CPU asks for.
    assign host_grant_s = bus.host_req &
                          ((((state_r == ST_IDLE) | (state_r == ST_WAIT)) & ~bus.cpu_mem_enable) |
                           (state_r == ST_STALL));

    assign wait_cnt_inc_s = wait_cnt_r + 4'd1;

    // Next-state and starvation counter logic
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (host_grant_s) begin
                    state_next_s    = ST_ACK;
                    wait_cnt_next_s = 4'd0;
                end else if (bus.host_req & bus.cpu_mem_enable) begin
                    // With a limit of one, the first lost cycle already exhausts the budget.
                    state_next_s    = (MAX_WAIT_C == 4'd1) ? ST_STALL : ST_WAIT;
                    wait_cnt_next_s = 4'd1;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.host_req) begin
                    state_next_s    = ST_IDLE;
                    wait_cnt_next_s = 4'd0;
                end else if (host_grant_s) begin
                    state_next_s    = ST_ACK;
                    wait_cnt_next_s = 4'd0;
                end else begin
                    wait_cnt_next_s = wait_cnt_inc_s;
                    state_next_s    = (wait_cnt_inc_s == MAX_WAIT_C) ? ST_STALL : ST_WAIT;
                end
            end
            ST_STALL: begin
                if (host_grant_s) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
                wait_cnt_next_s = 4'd0;
            end
            ST_ACK: begin
                state_next_s    = ST_IDLE;
                wait_cnt_next_s = 4'd0;
            end
            default: begin
                state_next_s    = ST_IDLE;
                wait_cnt_next_s = 4'd0;
            end
        endcase
    end

    // Memory bus multiplexer between host and CPU
    always_comb begin
        mem_enable_s = bus.cpu_mem_enable;
        mem_mode_s   = bus.cpu_mem_mode;
        mem_addr_s   = bus.cpu_addr;
        mem_wdata_s  = bus.cpu_wdata;
        if (host_grant_s) begin
            mem_enable_s = 1'b1;
            mem_mode_s   = bus.host_write ? MODE_WRITE : MODE_READ;
            mem_addr_s   = bus.host_addr;
            mem_wdata_s  = bus.host_wdata;
        end else begin
            mem_enable_s = bus.cpu_mem_enable;
        end
    end

    // State, counter and captured host read data
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 4'd0;
            host_rdata_r <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (host_grant_s) begin
                host_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_enable = mem_enable_s;
    assign bus.mem_mode   = mem_mode_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_run    = (state_r != ST_STALL);
    assign bus.host_ack   = (state_r == ST_ACK);
    assign bus.host_rdata = host_rdata_r;

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// Cycle-by-cycle vector table for the K12a memory arbiter plus a starvation-latency sequence.
module tb_k12a_mem_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        rst;
        logic        cen;
        logic        cmode;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        hreq;
        logic        hwr;
        logic [15:0] haddr;
        logic [7:0]  hwd;
        logic [7:0]  mrd;
        logic        e_host;
        logic        e_run;
        logic        e_ack;
        logic [7:0]  e_hrd;
    } vec_t;

    typedef struct {
        logic        men;
        logic        mmode;
        logic [15:0] maddr;
        logic [7:0]  mwd;
        logic [7:0]  crd;
        logic        run;
        logic        ack;
        logic [7:0]  hrd;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    k12a_mem_arbiter_if bus();

    k12a_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int   tests = 0;
    int   fails = 0;
    vec_t vt[$];
    exp_t sb_q[$];

    function automatic vec_t v(input logic rst, input logic cen, input logic cmode,
                               input logic [15:0] caddr, input logic [7:0] cwd,
                               input logic hreq, input logic hwr, input logic [15:0] haddr,
                               input logic [7:0] hwd, input logic [7:0] mrd,
                               input logic eh, input logic er, input logic ea,
                               input logic [7:0] ehrd);
        vec_t r;
        r.rst = rst; r.cen = cen; r.cmode = cmode; r.caddr = caddr; r.cwd = cwd;
        r.hreq = hreq; r.hwr = hwr; r.haddr = haddr; r.hwd = hwd; r.mrd = mrd;
        r.e_host = eh; r.e_run = er; r.e_ack = ea; r.e_hrd = ehrd;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs it must produce.
    task automatic apply(input vec_t r);
        exp_t e;
        reset_n            = r.rst;
        bus.cpu_mem_enable = r.cen;
        bus.cpu_mem_mode   = r.cmode;
        bus.cpu_addr       = r.caddr;
        bus.cpu_wdata      = r.cwd;
        bus.host_req       = r.hreq;
        bus.host_write     = r.hwr;
        bus.host_addr      = r.haddr;
        bus.host_wdata     = r.hwd;
        bus.mem_rdata      = r.mrd;
        if (r.e_host) begin
            e.men = 1'b1; e.mmode = r.hwr; e.maddr = r.haddr; e.mwd = r.hwd;
        end else begin
            e.men = r.cen; e.mmode = r.cmode; e.maddr = r.caddr; e.mwd = r.cwd;
        end
        e.crd = r.mrd;
        e.run = r.e_run;
        e.ack = r.e_ack;
        e.hrd = r.e_hrd;
        sb_q.push_back(e);
    endtask

    task automatic compare(input int idx);
        exp_t e;
        e = sb_q.pop_front();
        chk("mem_enable", idx, 16'(bus.mem_enable), 16'(e.men));
        chk("mem_mode",   idx, 16'(bus.mem_mode),   16'(e.mmode));
        chk("mem_addr",   idx, bus.mem_addr,        e.maddr);
        chk("mem_wdata",  idx, 16'(bus.mem_wdata),  16'(e.mwd));
        chk("cpu_rdata",  idx, 16'(bus.cpu_rdata),  16'(e.crd));
        chk("cpu_run",    idx, 16'(bus.cpu_run),    16'(e.run));
        chk("host_ack",   idx, 16'(bus.host_ack),   16'(e.ack));
        chk("host_rdata", idx, 16'(bus.host_rdata), 16'(e.hrd));
    endtask

    initial begin
        int cyc;
        int stalls;
        logic got;

        // reset, memory follows CPU
        vt.push_back(v(1'b0, 1'b1, 1'b1, 16'hBEEF, 8'h11, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00));
        vt.push_back(v(1'b0, 1'b0, 1'b0, 16'h0001, 8'h22, 1'b0, 1'b1, 16'hFFFF, 8'hFF, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h2000, 8'h55, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00));
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h2001, 8'h77, 1'b0, 1'b1, 16'h1111, 8'h11, 8'h88, 1'b0, 1'b1, 1'b0, 8'h00));
        // host read in a CPU-idle cycle
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h12, 1'b0, 1'b1, 1'b0, 8'hA5));
        // starved host write: four CPU cycles, then a stall cycle
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h0300, 8'hC3, 1'b1, 1'b1, 16'h0100, 8'h5A, 8'h10, 1'b0, 1'b1, 1'b0, 8'hA5));
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h0301, 8'hC3, 1'b1, 1'b1, 16'h0100, 8'h5A, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5));
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h0302, 8'hC3, 1'b1, 1'b1, 16'h0100, 8'h5A, 8'h12, 1'b0, 1'b1, 1'b0, 8'hA5));
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h0303, 8'hC3, 1'b1, 1'b1, 16'h0100, 8'h5A, 8'h13, 1'b0, 1'b1, 1'b0, 8'hA5));
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h0303, 8'hC3, 1'b1, 1'b1, 16'h0100, 8'h5A, 8'h77, 1'b1, 1'b0, 1'b0, 8'hA5));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0304, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h14, 1'b0, 1'b1, 1'b1, 8'h77));
        // CPU busy two cycles, then idle: host read in the third
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0500, 8'h00, 1'b1, 1'b0, 16'h0A0A, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'h77));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0501, 8'h00, 1'b1, 1'b0, 16'h0A0A, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 8'h77));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0A0A, 8'h00, 8'h9C, 1'b1, 1'b1, 1'b0, 8'h77));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h9C));
        // request abandoned while waiting
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0600, 8'h00, 1'b1, 1'b1, 16'h0B0B, 8'hEE, 8'h03, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0601, 8'h00, 1'b0, 1'b1, 16'h0B0B, 8'hEE, 8'h04, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 8'h9C));
        // request abandoned in the stall cycle: CPU write reaches memory, no ack
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0610, 8'h00, 1'b1, 1'b1, 16'h0C0C, 8'hDD, 8'h06, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0611, 8'h00, 1'b1, 1'b1, 16'h0C0C, 8'hDD, 8'h07, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0612, 8'h00, 1'b1, 1'b1, 16'h0C0C, 8'hDD, 8'h08, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0613, 8'h00, 1'b1, 1'b1, 16'h0C0C, 8'hDD, 8'h09, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b1, 16'h0700, 8'h99, 1'b0, 1'b1, 16'h0C0C, 8'hDD, 8'h42, 1'b0, 1'b0, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0701, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h9C));
        // reset asserted during the stall cycle
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0800, 8'h00, 1'b1, 1'b0, 16'h0D0D, 8'h00, 8'h0B, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0801, 8'h00, 1'b1, 1'b0, 16'h0D0D, 8'h00, 8'h0C, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0802, 8'h00, 1'b1, 1'b0, 16'h0D0D, 8'h00, 8'h0D, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0803, 8'h00, 1'b1, 1'b0, 16'h0D0D, 8'h00, 8'h0E, 1'b0, 1'b1, 1'b0, 8'h9C));
        vt.push_back(v(1'b0, 1'b1, 1'b1, 16'h0804, 8'hAA, 1'b1, 1'b0, 16'h0D0D, 8'h00, 8'h5F, 1'b1, 1'b0, 1'b0, 8'h9C));
        vt.push_back(v(1'b1, 1'b1, 1'b0, 16'h0805, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h0F, 1'b0, 1'b1, 1'b0, 8'h00));
        // request held through ACK: no grant in ACK, new access only from IDLE
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0E0E, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0E0E, 8'h00, 8'h4D, 1'b0, 1'b1, 1'b1, 8'h3C));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0E0E, 8'h00, 8'h5E, 1'b1, 1'b1, 1'b0, 8'h3C));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5E));
        vt.push_back(v(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5E));

        #1;
        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i]);
            @(negedge clock);
            compare(i);
            @(posedge clock);
            #1;
        end

        // Worst-case latency with the CPU always busy: ack after MAX_WAIT+1 cycles, one stall.
        reset_n            = 1'b1;
        bus.cpu_mem_enable = 1'b1;
        bus.cpu_mem_mode   = 1'b0;
        bus.cpu_addr       = 16'h0900;
        bus.cpu_wdata      = 8'h00;
        bus.host_req       = 1'b1;
        bus.host_write     = 1'b0;
        bus.host_addr      = 16'h0F0F;
        bus.host_wdata     = 8'h00;
        bus.mem_rdata      = 8'h6B;
        cyc    = 0;
        stalls = 0;
        got    = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clock);
            if (!bus.cpu_run) stalls++;
            if (bus.host_ack) begin
                got = 1'b1;
            end else begin
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        chk("seq_ack_seen",   0, 16'(got),             16'd1);
        chk("seq_latency",    0, 16'(cyc),             16'(MAX_WAIT + 1));
        chk("seq_stalls",     0, 16'(stalls),          16'd1);
        chk("seq_host_rdata", 0, 16'(bus.host_rdata),  16'h006B);
        @(posedge clock);
        #1;
        bus.host_req = 1'b0;
        @(negedge clock);
        chk("seq_after_ack",  0, 16'(bus.host_ack),    16'd0);
        chk("seq_run_after",  0, 16'(bus.cpu_run),     16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
